// File: rtl/uart_csr_fifo.sv
// Wishbone CSR block for the UART: clock-frequency register, TX/RX FIFOs,
// level/threshold status and sticky write-1-to-clear interrupt flags.
module uart_csr_fifo #(
  parameter int          ADDRESS_WIDTH   = 5,
  parameter int          DATA_WIDTH      = 8,
  parameter int          TX_DEPTH        = 8,
  parameter int          RX_DEPTH        = 8,
  parameter logic [31:0] CLOCK_FREQ_INIT = 32'h0001C200,
  parameter bit          ERROR_STATUS    = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  output logic                     o_wb_stall,
  input  logic [ADDRESS_WIDTH-1:0] i_wb_adr,
  input  logic                     i_wb_we,
  input  logic [31:0]              i_wb_dat,
  input  logic [3:0]               i_wb_sel,
  output logic                     o_wb_ack,
  output logic                     o_wb_err,
  output logic                     o_wb_rty,
  output logic [31:0]              o_wb_dat,
  output logic [31:0]              o_clock_freq,
  output logic [DATA_WIDTH-1:0]    o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  input  logic [DATA_WIDTH-1:0]    i_rx_data,
  input  logic                     i_rx_valid,
  output logic                     o_irq
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_LW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_LW = RX_AW + 1;

  logic [31:0]           clock_freq_q, clock_freq_d;
  logic [4:0]            irq_en_q, irq_en_d;
  logic [7:0]            rx_thresh_q, rx_thresh_d;
  // sticky bit 0: rx_overrun, bit 1: tx_overflow, bit 2: rx_underflow
  logic [2:0]            sticky_q, sticky_d;
  logic                  irq_q, irq_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [31:0]           dat_q, dat_d;
  logic [TX_LW-1:0]      tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [RX_LW-1:0]      rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [DATA_WIDTH-1:0] tx_mem_q [TX_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_q [RX_DEPTH];

  logic [TX_LW-1:0]      tx_level;
  logic [RX_LW-1:0]      rx_level;
  logic                  tx_empty, tx_full, rx_empty, rx_full;
  logic [DATA_WIDTH-1:0] tx_head, rx_head;
  logic [7:0]            thresh_eff;
  logic [4:0]            irq_status;
  logic                  accept;
  logic                  tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
  logic                  set_underflow;
  logic [2:0]            w1c;
  logic                  unused_bits;

  assign unused_bits = ^{i_wb_adr, i_wb_dat, i_wb_sel};

  // FIFO occupancy, heads and interrupt status vector
  always_comb begin
    tx_level   = tx_wr_q - tx_rd_q;
    rx_level   = rx_wr_q - rx_rd_q;
    tx_empty   = (tx_level == {TX_LW{1'b0}});
    rx_empty   = (rx_level == {RX_LW{1'b0}});
    tx_full    = (tx_level == TX_LW'(TX_DEPTH));
    rx_full    = (rx_level == RX_LW'(RX_DEPTH));
    tx_head    = tx_mem_q[tx_rd_q[TX_AW-1:0]];
    rx_head    = rx_mem_q[rx_rd_q[RX_AW-1:0]];
    thresh_eff = (rx_thresh_q == 8'd0) ? 8'd1 : rx_thresh_q;
    irq_status = {sticky_q, tx_empty, (8'(rx_level) >= thresh_eff)};
  end

  assign accept = i_wb_cyc & i_wb_stb & ~o_wb_stall;

  // Bus access decode: register writes, FIFO push/pop requests, response data
  always_comb begin
    clock_freq_d  = clock_freq_q;
    irq_en_d      = irq_en_q;
    rx_thresh_d   = rx_thresh_q;
    ack_d         = 1'b0;
    err_d         = 1'b0;
    dat_d         = 32'd0;
    tx_push_req   = 1'b0;
    rx_pop        = 1'b0;
    set_underflow = 1'b0;
    w1c           = 3'b000;
    if (accept) begin
      ack_d = 1'b1;
      case (i_wb_adr[4:2])
        3'd0: begin
          if (i_wb_we) begin
            for (int b = 0; b < 4; b++) begin
              if (i_wb_sel[b]) clock_freq_d[8*b +: 8] = i_wb_dat[8*b +: 8];
              else             clock_freq_d[8*b +: 8] = clock_freq_q[8*b +: 8];
            end
          end else begin
            dat_d = clock_freq_q;
          end
        end
        3'd1: begin
          if (i_wb_we)        dat_d = 32'd0;
          else if (!rx_empty) begin
            rx_pop = 1'b1;
            dat_d  = 32'(rx_head);
          end else begin
            set_underflow = 1'b1;
          end
        end
        3'd2: tx_push_req = i_wb_we & i_wb_sel[0];
        3'd3: begin
          if (i_wb_we) dat_d = 32'd0;
          else         dat_d = {12'd0, tx_full, tx_empty, rx_full, rx_empty,
                                8'(tx_level), 8'(rx_level)};
        end
        3'd4: begin
          if (i_wb_we && i_wb_sel[0]) irq_en_d = i_wb_dat[4:0];
          else if (!i_wb_we)          dat_d    = {27'd0, irq_en_q};
          else                        irq_en_d = irq_en_q;
        end
        3'd5: begin
          if (i_wb_we && i_wb_sel[0]) w1c   = i_wb_dat[4:2];
          else if (!i_wb_we)          dat_d = {27'd0, irq_status};
          else                        w1c   = 3'b000;
        end
        3'd6: begin
          if (i_wb_we && i_wb_sel[0]) rx_thresh_d = i_wb_dat[7:0];
          else if (!i_wb_we)          dat_d       = {24'd0, rx_thresh_q};
          else                        rx_thresh_d = rx_thresh_q;
        end
        3'd7: begin
          if (ERROR_STATUS) begin
            ack_d = 1'b0;
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
          end
        end
        default: ack_d = 1'b1;
      endcase
    end else begin
      ack_d = 1'b0;
    end
  end

  // A push into a full FIFO is only accepted when the same cycle also pops
  always_comb begin
    tx_pop   = ~tx_empty & i_tx_ready;
    tx_push  = tx_push_req & (~tx_full | tx_pop);
    rx_push  = i_rx_valid & (~rx_full | rx_pop);
    tx_wr_d  = tx_wr_q + {{(TX_LW-1){1'b0}}, tx_push};
    tx_rd_d  = tx_rd_q + {{(TX_LW-1){1'b0}}, tx_pop};
    rx_wr_d  = rx_wr_q + {{(RX_LW-1){1'b0}}, rx_push};
    rx_rd_d  = rx_rd_q + {{(RX_LW-1){1'b0}}, rx_pop};
    sticky_d = (sticky_q & ~w1c) |
               {set_underflow, tx_push_req & tx_full & ~tx_pop, i_rx_valid & rx_full & ~rx_pop};
    irq_d    = |(irq_status & irq_en_q);
  end

  // Control and status registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clock_freq_q <= CLOCK_FREQ_INIT;
      irq_en_q     <= 5'd0;
      rx_thresh_q  <= 8'd1;
      sticky_q     <= 3'd0;
      irq_q        <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      dat_q        <= 32'd0;
      tx_wr_q      <= {TX_LW{1'b0}};
      tx_rd_q      <= {TX_LW{1'b0}};
      rx_wr_q      <= {RX_LW{1'b0}};
      rx_rd_q      <= {RX_LW{1'b0}};
    end else begin
      clock_freq_q <= clock_freq_d;
      irq_en_q     <= irq_en_d;
      rx_thresh_q  <= rx_thresh_d;
      sticky_q     <= sticky_d;
      irq_q        <= irq_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      dat_q        <= dat_d;
      tx_wr_q      <= tx_wr_d;
      tx_rd_q      <= tx_rd_d;
      rx_wr_q      <= rx_wr_d;
      rx_rd_q      <= rx_rd_d;
    end
  end

  // FIFO storage; contents are don't-care until the write pointer covers them
  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem_q[tx_wr_q[TX_AW-1:0]] <= i_wb_dat[DATA_WIDTH-1:0];
    if (rx_push) rx_mem_q[rx_wr_q[RX_AW-1:0]] <= i_rx_data;
  end

  assign o_wb_stall   = ack_q | err_q;
  assign o_wb_ack     = ack_q;
  assign o_wb_err     = err_q;
  assign o_wb_rty     = 1'b0;
  assign o_wb_dat     = dat_q;
  assign o_clock_freq = clock_freq_q;
  assign o_tx_data    = tx_head;
  assign o_tx_valid   = ~tx_empty;
  assign o_irq        = irq_q;

endmodule

// File: tb/tb_uart_csr_fifo.sv
// Directed bench for uart_csr_fifo (ERROR_STATUS=1, 8-deep FIFOs).
module tb_uart_csr_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [4:0]  adr = 5'd0;
  logic [31:0] wdat = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic        stall, ack, err, rty;
  logic [31:0] rdat, clock_freq;
  logic [7:0]  tx_data, rx_data = 8'd0;
  logic        tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, irq;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  uart_csr_fifo #(.ERROR_STATUS(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_stall(stall),
    .i_wb_adr(adr), .i_wb_we(we), .i_wb_dat(wdat), .i_wb_sel(sel),
    .o_wb_ack(ack), .o_wb_err(err), .o_wb_rty(rty), .o_wb_dat(rdat),
    .o_clock_freq(clock_freq), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_irq(irq)
  );

  // One access: accepted at the first posedge, response sampled in the next cycle
  task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic k, output logic e);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rd = rdat; k = ack; e = err;
    @(posedge clk); #1;
  endtask

  task automatic rx_push(input logic [7:0] c);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = c;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] r; logic k, e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if ({irq, tx_valid, ack, err, stall} !== 5'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 00000", {irq, tx_valid, ack, err, stall}); end
    bus(1'b0, 5'h00, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h0001C200 || k !== 1'b1) begin errors++; $display("FAIL reset_clock_freq: got %h ack %b expected 0001c200 ack 1", r, k); end
    bus(1'b0, 5'h0C, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h00050000) begin errors++; $display("FAIL reset_status: got %h expected 00050000", r); end
    bus(1'b0, 5'h18, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL reset_thresh: got %h expected 00000001", r); end
  endtask

  task automatic test_clock_freq;
    logic [31:0] r; logic k, e;
    bus(1'b1, 5'h00, 32'hAABBCCDD, 4'b0101, r, k, e);
    checks++; if (clock_freq !== 32'h00BBC2DD) begin errors++; $display("FAIL clock_freq_sel: got %h expected 00bbc2dd", clock_freq); end
    bus(1'b0, 5'h00, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h00BBC2DD) begin errors++; $display("FAIL clock_freq_read: got %h expected 00bbc2dd", r); end
  endtask

  task automatic test_tx;
    logic [31:0] r; logic k, e;
    tx_ready = 1'b0;
    bus(1'b1, 5'h08, 32'h41, 4'h1, r, k, e);
    bus(1'b1, 5'h08, 32'h42, 4'h1, r, k, e);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL tx_head: got v%b %h expected v1 41", tx_valid, tx_data); end
    bus(1'b0, 5'h0C, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h00010200) begin errors++; $display("FAIL tx_status: got %h expected 00010200", r); end
    bus(1'b0, 5'h08, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL tx_read_zero: got %h expected 00000000", r); end
    @(negedge clk); tx_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin errors++; $display("FAIL tx_pop1: got v%b %h expected v1 42", tx_valid, tx_data); end
    @(posedge clk); #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_pop2: got valid %b expected 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_tx_overflow;
    logic [31:0] r; logic k, e;
    for (int i = 0; i < 9; i++) bus(1'b1, 5'h08, 32'h10 + i, 4'h1, r, k, e);
    bus(1'b0, 5'h0C, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h00090800) begin errors++; $display("FAIL tx_full_status: got %h expected 00090800", r); end
    bus(1'b0, 5'h14, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h08) begin errors++; $display("FAIL tx_overflow_flag: got %h expected 00000008", r); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); tx_ready = 1'b1;
      checks++; if (tx_data !== 8'(32'h10 + i)) begin errors++; $display("FAIL tx_drain[%0d]: got %h expected %h", i, tx_data, 8'(32'h10 + i)); end
    end
    @(negedge clk); tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained: got valid %b expected 0", tx_valid); end
    bus(1'b1, 5'h14, 32'h08, 4'h1, r, k, e);
    bus(1'b0, 5'h14, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h02) begin errors++; $display("FAIL tx_overflow_clear: got %h expected 00000002", r); end
  endtask

  task automatic test_rx_overrun;
    logic [31:0] r; logic k, e;
    for (int i = 0; i < 9; i++) rx_push(8'(32'h60 + i));
    bus(1'b0, 5'h0C, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h00060008) begin errors++; $display("FAIL rx_full_status: got %h expected 00060008", r); end
    bus(1'b0, 5'h14, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h07) begin errors++; $display("FAIL rx_overrun_flag: got %h expected 00000007", r); end
    for (int i = 0; i < 8; i++) begin
      bus(1'b0, 5'h04, 32'd0, 4'hF, r, k, e);
      checks++; if (r !== 32'h60 + i) begin errors++; $display("FAIL rx_order[%0d]: got %h expected %h", i, r, 32'h60 + i); end
    end
    bus(1'b1, 5'h14, 32'h04, 4'h1, r, k, e);
    bus(1'b0, 5'h14, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h02) begin errors++; $display("FAIL rx_overrun_clear: got %h expected 00000002", r); end
  endtask

  task automatic test_irq_thresh;
    logic [31:0] r; logic k, e;
    bus(1'b1, 5'h18, 32'h3, 4'h1, r, k, e);
    bus(1'b1, 5'h10, 32'h1, 4'h1, r, k, e);
    rx_push(8'hA1); rx_push(8'hA2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_below: got %b expected 0", irq); end
    rx_push(8'hA3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b expected 0", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_thresh: got %b expected 1", irq); end
    bus(1'b0, 5'h04, 32'd0, 4'hF, r, k, e);
    checks++; if (irq !== 1'b0 || r !== 32'hA1) begin errors++; $display("FAIL irq_after_read: got irq %b data %h expected 0 a1", irq, r); end
    bus(1'b0, 5'h04, 32'd0, 4'hF, r, k, e);
    bus(1'b0, 5'h04, 32'd0, 4'hF, r, k, e);
    bus(1'b1, 5'h18, 32'h0, 4'h1, r, k, e);
    rx_push(8'hB0);
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_thresh_zero: got %b expected 1", irq); end
    bus(1'b0, 5'h04, 32'd0, 4'hF, r, k, e);
    bus(1'b1, 5'h10, 32'h0, 4'h1, r, k, e);
  endtask

  task automatic test_rx_full_pop;
    logic [31:0] r; logic k, e;
    for (int i = 0; i < 8; i++) rx_push(8'(32'h70 + i));
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 5'h04; rx_valid = 1'b1; rx_data = 8'h7F;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; rx_valid = 1'b0;
    checks++; if (ack !== 1'b1 || rdat !== 32'h70) begin errors++; $display("FAIL rx_pop_push: got ack %b data %h expected 1 70", ack, rdat); end
    @(posedge clk); #1;
    bus(1'b0, 5'h0C, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h00060008) begin errors++; $display("FAIL rx_pop_push_level: got %h expected 00060008", r); end
    bus(1'b0, 5'h14, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h03) begin errors++; $display("FAIL rx_no_overrun: got %h expected 00000003", r); end
    for (int i = 1; i < 9; i++) begin
      bus(1'b0, 5'h04, 32'd0, 4'hF, r, k, e);
      checks++; if (r !== ((i == 8) ? 32'h7F : 32'h70 + i)) begin errors++; $display("FAIL rx_pp_order[%0d]: got %h", i, r); end
    end
    bus(1'b0, 5'h04, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h0 || k !== 1'b1) begin errors++; $display("FAIL rx_empty_read: got %h ack %b expected 00000000 ack 1", r, k); end
    bus(1'b0, 5'h14, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h12) begin errors++; $display("FAIL rx_underflow_flag: got %h expected 00000012", r); end
    bus(1'b1, 5'h14, 32'h10, 4'h1, r, k, e);
  endtask

  task automatic test_unmapped;
    logic [31:0] r; logic k, e;
    bus(1'b0, 5'h1C, 32'd0, 4'hF, r, k, e);
    checks++; if (e !== 1'b1 || k !== 1'b0 || r !== 32'h0) begin errors++; $display("FAIL unmapped_err: got err %b ack %b data %h expected 1 0 0", e, k, r); end
  endtask

  task automatic test_reset_pending;
    logic [31:0] r; logic k, e;
    bus(1'b1, 5'h08, 32'h55, 4'h1, r, k, e);
    bus(1'b1, 5'h18, 32'h5, 4'h1, r, k, e);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_tx: got %b expected 1", tx_valid); end
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 5'h00; wdat = 32'h12345678; sel = 4'hF;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({ack, err, stall} !== 3'b000) begin errors++; $display("FAIL reset_drops_ack: got %b expected 000", {ack, err, stall}); end
    checks++; if (clock_freq !== 32'h0001C200 || tx_valid !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL reset_regs: got %h v%b irq%b expected 0001c200 v0 irq0", clock_freq, tx_valid, irq); end
    bus(1'b0, 5'h18, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL reset_thresh2: got %h expected 00000001", r); end
    bus(1'b0, 5'h0C, 32'd0, 4'hF, r, k, e);
    checks++; if (r !== 32'h00050000) begin errors++; $display("FAIL reset_status2: got %h expected 00050000", r); end
  endtask

  initial begin
    test_reset();
    test_clock_freq();
    test_tx();
    test_tx_overflow();
    test_rx_overrun();
    test_irq_thresh();
    test_rx_full_pop();
    test_unmapped();
    test_reset_pending();
    checks++; if (rty !== 1'b0) begin errors++; $display("FAIL rty_tied: got %b expected 0", rty); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
